debug_scanner: RTL and testbench
================================

# debug_scanner

Host-side master for the CPU debug port. On request it halts the core through `debug_en`, sweeps `debug_addr` over a configured register window, captures each `debug_data` word, and streams the captured words out as bytes over a valid/ready channel to a UART or display front-end. It also converts a single-cycle step request into a qualified `debug_step` pulse while the core is halted. It sits beside `mips` at board top level.

## Interface

- `ADDR_FIRST`, default 0: first debug address swept.
- `ADDR_LAST`, default 127: last debug address swept. Must be ≥ `ADDR_FIRST` and ≤ 127.
- `SETTLE`, default 2: cycles `debug_addr` is held before `debug_data` is sampled. Must be ≥ 1.

Ports:

- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, asynchronous, active-high.
- `halt` in 1: level; the user holds the core halted.
- `scan_req` in 1: one-cycle pulse; starts a sweep.
- `step_req` in 1: one-cycle pulse; requests a single step.
- `debug_en` out 1: to core; core is frozen while high.
- `debug_step` out 1: to core; one-cycle step pulse.
- `debug_addr` out 7: to core; debug register select.
- `debug_data` in 32: from core; combinational read of `debug_addr`.
- `out_valid` out 1: stream byte valid.
- `out_data` out 8: stream byte.
- `out_ready` in 1: sink accepts the byte when it is high together with `out_valid`.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when a sweep completes.

## Operation

FSM states: IDLE, SETTLE, CAPTURE, SEND, NEXT, DONE.

- **IDLE**
  - `scan_req` = 1 moves to SETTLE, loads `debug_addr` = `ADDR_FIRST`, and clears the settle counter.
  - `scan_req` in any other state is ignored and not queued.
- **SETTLE**
  - Lasts exactly `SETTLE` cycles, then moves to CAPTURE.
- **CAPTURE**
  - One cycle.
  - Latches `{1'b0, debug_addr, debug_data}` into a 40-bit frame register.
  - Sets byte index = 0, then moves to SEND.
- **SEND**
  - Byte order per frame: `{0, addr}`, then `data[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
  - `out_data` shows the current byte and `out_valid` = 1.
  - On handshake the index advances.
  - After the 5th handshake, moves to NEXT.
- **NEXT**
  - One cycle.
  - If `debug_addr` == `ADDR_LAST`, moves to DONE.
  - Otherwise increments `debug_addr` and returns to SETTLE.
  - `debug_addr` never wraps past `ADDR_LAST`.
- **DONE**
  - One cycle with `done` = 1, then moves to IDLE.

Outputs and the step path:

- `debug_en` = `halt` OR (state ≠ IDLE). The core stays frozen for the entire sweep, including DONE.
- `busy` = (state ≠ IDLE).
- `debug_step` pulses for one cycle on the cycle after a cycle with `step_req` = 1, but only if the state is IDLE and `halt` = 1. Otherwise the request is dropped.
- Simultaneous `scan_req` and `step_req` in IDLE: the scan wins and the step is dropped.

Reset:

- Every output resets to 0, except `debug_addr`, which resets to `ADDR_FIRST`.
- `rst` asserted mid-sweep aborts immediately: `out_valid` drops asynchronously, no `done` pulse is produced, and the state returns to IDLE.

## Timing

- Let edge E sample `scan_req`.
- `busy`, `debug_en`, and `debug_addr` = `ADDR_FIRST` are visible after E.
- CAPTURE occupies the cycle after E+`SETTLE`. The first `out_valid` is seen after edge E+`SETTLE`+1.
- With `out_ready` tied high, each address costs `SETTLE` + 1 (CAPTURE) + 5 (SEND) + 1 (NEXT) cycles.
- Total sweep cost with `out_ready` tied high, N = `ADDR_LAST` − `ADDR_FIRST` + 1:
  - N·(`SETTLE` + 7) + 1 cycles, plus 1 cycle per address with the checksum enabled.
- While `out_valid` = 1 and `out_ready` = 0, `out_data` must hold stable.
- `out_valid` never depends combinationally on `out_ready`.
- `debug_step` is registered; there is a one-cycle latency from `step_req`.

## Configuration

- `DEBUG_SCANNER_CHECKSUM_EN` defined:
  - Each frame gains a 6th byte, equal to the XOR of the 5 preceding bytes.
  - SEND completes after 6 handshakes.
- Not defined: 5-byte frames, and no checksum logic is present.

## Structure

- Shared package `debug_pkg` holds:
  - the FSM state enum;
  - `DBG_ADDR_W` = 7;
  - `DBG_DATA_W` = 32;
  - the frame byte count constant, conditional on the macro.
- One sub-module, `byte_serializer`: loads the frame register, runs the valid/ready byte handshake, and signals "last byte accepted". The checksum accumulator lives inside it.

## Test plan

- **Sweep 0..3 with `SETTLE`=2 and `out_ready`=1:** the core model returns `data = 0xA5000000 | addr`.
  - Bytes are `00 A5 00 00 00`, `01 A5 00 00 01`, … `03 A5 00 00 03`.
  - `done` pulses 37 cycles after E.
  - `debug_en` = 1 throughout the sweep.
- **Backpressure:** `out_ready` toggles 0/1 every cycle. The byte sequence is identical to the previous test, and `out_data` is stable whenever `out_ready` = 0.
- **Steps:** `halt`=1 with `step_req` pulses at 3 spaced cycles gives exactly 3 one-cycle `debug_step` pulses. With `halt`=0, `step_req` gives no pulse.
- **Collisions:** `scan_req` arrives mid-sweep and is ignored; the byte count is unchanged. `step_req` during a sweep produces no `debug_step`.
- **Reset mid-frame:** `rst` is asserted during byte 3 of address 2. `out_valid`, `busy`, and `debug_en` fall immediately, with `halt`=0. A new `scan_req` restarts cleanly at `ADDR_FIRST`.
- **With `DEBUG_SCANNER_CHECKSUM_EN`:** address 1, data `0x12345678` produces `01 12 34 56 78 09`.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and constants for the debug scanner.
// DEBUG_SCANNER_CHECKSUM_EN appends an XOR checksum byte to every frame.
package debug_pkg;

    localparam int DBG_ADDR_W = 7;
    localparam int DBG_DATA_W = 32;
    localparam int FRAME_W    = 1 + DBG_ADDR_W + DBG_DATA_W;

`ifdef DEBUG_SCANNER_CHECKSUM_EN
    localparam int FRAME_BYTES = 6;
`else
    localparam int FRAME_BYTES = 5;
`endif

    localparam logic [2:0] FRAME_LAST_IDX = 3'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } scan_state_e;

endpackage

// File: rtl/byte_serializer.sv
// Streams a captured 40-bit frame MSB-byte first over valid/ready.
// With DEBUG_SCANNER_CHECKSUM_EN a trailing XOR byte of the first five is sent.
module byte_serializer
    import debug_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    output logic               last_accepted
);

    logic [FRAME_W-1:0] frame_r;
    logic [FRAME_W-1:0] shifted_s;
    logic [2:0]         idx_r;
    logic               valid_r;
    logic               accept_s;
`ifdef DEBUG_SCANNER_CHECKSUM_EN
    logic [7:0]         csum_r;
`endif

    assign accept_s      = valid_r & out_ready;
    assign last_accepted = accept_s & (idx_r == FRAME_LAST_IDX);
    assign out_valid     = valid_r;
    assign out_data      = frame_r[FRAME_W-1 -: 8];

    // Next frame contents after the current top byte is accepted.
    always_comb begin
`ifdef DEBUG_SCANNER_CHECKSUM_EN
        if (idx_r == 3'd4) begin
            shifted_s = {csum_r ^ frame_r[FRAME_W-1 -: 8], {(FRAME_W-8){1'b0}}};
        end else begin
            shifted_s = {frame_r[FRAME_W-9:0], 8'h00};
        end
`else
        shifted_s = {frame_r[FRAME_W-9:0], 8'h00};
`endif
    end

    // Frame shift register, byte index and valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_r <= {FRAME_W{1'b0}};
            idx_r   <= 3'd0;
            valid_r <= 1'b0;
`ifdef DEBUG_SCANNER_CHECKSUM_EN
            csum_r  <= 8'h00;
`endif
        end else if (load) begin
            frame_r <= frame;
            idx_r   <= 3'd0;
            valid_r <= 1'b1;
`ifdef DEBUG_SCANNER_CHECKSUM_EN
            csum_r  <= 8'h00;
`endif
        end else if (accept_s) begin
            frame_r <= shifted_s;
`ifdef DEBUG_SCANNER_CHECKSUM_EN
            csum_r  <= csum_r ^ frame_r[FRAME_W-1 -: 8];
`endif
            if (idx_r == FRAME_LAST_IDX) begin
                idx_r   <= 3'd0;
                valid_r <= 1'b0;
            end else begin
                idx_r   <= idx_r + 3'd1;
            end
        end
    end

endmodule

// File: rtl/debug_scanner.sv
// Debug-port master: halts the core, sweeps a register window and streams it out.
// Build option DEBUG_SCANNER_CHECKSUM_EN adds a checksum byte per frame.
module debug_scanner
    import debug_pkg::*;
#(
    parameter int ADDR_FIRST = 0,
    parameter int ADDR_LAST  = 127,
    parameter int SETTLE     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  scan_req,
    input  logic                  step_req,
    output logic                  debug_en,
    output logic                  debug_step,
    output logic [DBG_ADDR_W-1:0] debug_addr,
    input  logic [DBG_DATA_W-1:0] debug_data,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [DBG_ADDR_W-1:0] ADDR_FIRST_C = DBG_ADDR_W'(ADDR_FIRST);
    localparam logic [DBG_ADDR_W-1:0] ADDR_LAST_C  = DBG_ADDR_W'(ADDR_LAST);
    localparam logic [15:0]           SETTLE_LAST  = 16'(SETTLE - 1);

    scan_state_e           state_r;
    scan_state_e           next_state_s;
    logic [DBG_ADDR_W-1:0] debug_addr_r;
    logic [15:0]           settle_cnt_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  debug_step_r;
    logic                  load_s;
    logic                  last_accepted_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (scan_req) next_state_s = ST_SETTLE;
                else          next_state_s = ST_IDLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) next_state_s = ST_CAPTURE;
                else                             next_state_s = ST_SETTLE;
            end
            ST_CAPTURE: next_state_s = ST_SEND;
            ST_SEND: begin
                if (last_accepted_s) next_state_s = ST_NEXT;
                else                 next_state_s = ST_SEND;
            end
            ST_NEXT: begin
                if (debug_addr_r == ADDR_LAST_C) next_state_s = ST_DONE;
                else                             next_state_s = ST_SETTLE;
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Address, settle counter and registered status/step outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            debug_addr_r <= ADDR_FIRST_C;
            settle_cnt_r <= 16'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            debug_step_r <= 1'b0;
        end else begin
            busy_r       <= (next_state_s != ST_IDLE);
            done_r       <= (next_state_s == ST_DONE);
            // A scan request in the same cycle takes priority over a step.
            debug_step_r <= step_req & halt & ~scan_req & (state_r == ST_IDLE);
            if ((state_r == ST_IDLE) && scan_req) begin
                debug_addr_r <= ADDR_FIRST_C;
                settle_cnt_r <= 16'd0;
            end else if ((state_r == ST_NEXT) && (debug_addr_r != ADDR_LAST_C)) begin
                debug_addr_r <= debug_addr_r + 7'd1;
                settle_cnt_r <= 16'd0;
            end else if (state_r == ST_SETTLE) begin
                settle_cnt_r <= settle_cnt_r + 16'd1;
            end
        end
    end

    assign load_s = (state_r == ST_CAPTURE);

    byte_serializer u_ser (
        .clk          (clk),
        .rst          (rst),
        .load         (load_s),
        .frame        ({1'b0, debug_addr_r, debug_data}),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .last_accepted(last_accepted_s)
    );

    assign debug_addr = debug_addr_r;
    assign debug_en   = halt | busy_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign debug_step = debug_step_r;

endmodule

// File: tb/tb_debug_scanner.sv
// Self-checking bench for debug_scanner: directed sweeps with a byte-list
// reference model, backpressure, step qualification, collisions and reset abort.
module tb_debug_scanner;

    localparam int FIRST    = 0;
    localparam int LAST     = 3;
    localparam int SETTLE_C = 2;
    localparam int N        = LAST - FIRST + 1;
`ifdef DEBUG_SCANNER_CHECKSUM_EN
    localparam int FB = 6;
`else
    localparam int FB = 5;
`endif

    logic        clk = 1'b0;
    logic        rst, halt, scan_req, step_req, out_ready;
    logic        debug_en, debug_step, out_valid, busy, done;
    logic [6:0]  debug_addr;
    logic [31:0] debug_data;
    logic [7:0]  out_data;

    logic [31:0] mem [128];
    logic [7:0]  got [$];
    logic [7:0]  expq [$];
    logic        hold_pend;
    logic [7:0]  hold_data;
    int total = 0, bad = 0;
    int k, first_valid_k, done_cnt, step_cnt, en_bad, hold_total, hold_bad, ready_mode;

    always #5 clk = ~clk;

    // Core model: combinational register read.
    assign debug_data = mem[debug_addr];

    debug_scanner #(.ADDR_FIRST(FIRST), .ADDR_LAST(LAST), .SETTLE(SETTLE_C)) dut (
        .clk(clk), .rst(rst), .halt(halt), .scan_req(scan_req), .step_req(step_req),
        .debug_en(debug_en), .debug_step(debug_step), .debug_addr(debug_addr),
        .debug_data(debug_data), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: log the handshake about to happen, advance, then observe.
    task automatic cycle();
        if (out_valid && out_ready) got.push_back(out_data);
        hold_pend = out_valid && !out_ready;
        hold_data = out_data;
        @(posedge clk);
        #1;
        k++;
        if (hold_pend) begin
            hold_total++;
            if (!(out_valid === 1'b1 && out_data === hold_data)) hold_bad++;
        end
        if (busy && !debug_en) en_bad++;
        if (done) done_cnt++;
        if (debug_step) step_cnt++;
        if (out_valid && first_valid_k < 0) first_valid_k = k;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Reference: every address in the window yields {addr, data bytes MSB first[, xor]}.
    task automatic build_expected();
        expq.delete();
        for (int a = FIRST; a <= LAST; a++) begin
            logic [7:0] b [6];
            b[0] = 8'(a);
            b[1] = 8'(mem[a] >> 24);
            b[2] = 8'(mem[a] >> 16);
            b[3] = 8'(mem[a] >> 8);
            b[4] = 8'(mem[a]);
            b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
            for (int j = 0; j < FB; j++) expq.push_back(b[j]);
        end
    endtask

    task automatic compare_bytes(input string tag);
        build_expected();
        chk({tag, "_count"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got[i], expq[i]);
    endtask

    task automatic start_scan(input logic with_step);
        got.delete();
        done_cnt = 0; step_cnt = 0; en_bad = 0; hold_total = 0; hold_bad = 0;
        first_valid_k = -1;
        scan_req = 1'b1;
        step_req = with_step;
        cycle();
        scan_req = 1'b0;
        step_req = 1'b0;
        k = 0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 2000) begin
            cycle();
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; halt = 1'b0; scan_req = 1'b0; step_req = 1'b0; out_ready = 1'b1;
        ready_mode = 0; k = 0; first_valid_k = -1;
        done_cnt = 0; step_cnt = 0; en_bad = 0; hold_total = 0; hold_bad = 0;
        for (int a = 0; a < 128; a++) mem[a] = 32'hA500_0000 | 32'(a);

        // Reset state
        repeat (3) cycle();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_debug_en", 64'(debug_en), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_debug_step", 64'(debug_step), 64'd0);
        chk("rst_debug_addr", 64'(debug_addr), 64'(FIRST));
        rst = 1'b0;
        repeat (2) cycle();

        // Sweep with out_ready tied high
        start_scan(1'b0);
        chk("t1_busy_after_E", 64'(busy), 64'd1);
        chk("t1_en_after_E", 64'(debug_en), 64'd1);
        chk("t1_addr_after_E", 64'(debug_addr), 64'(FIRST));
        wait_done("t1");
        // DONE is the last of N*(SETTLE+2+FB)+1 cycles counted from the cycle after E.
        chk("t1_done_latency", 64'(k), 64'(N * (SETTLE_C + 2 + FB)));
        chk("t1_first_valid", 64'(first_valid_k), 64'(SETTLE_C + 1));
        cycle();
        chk("t1_done_width", 64'(done), 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_en_end", 64'(debug_en), 64'd0);
        chk("t1_en_hold", 64'(en_bad), 64'd0);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        compare_bytes("t1");

        // Backpressure: out_ready toggles every cycle
        ready_mode = 1;
        start_scan(1'b0);
        wait_done("t2");
        cycle();
        compare_bytes("t2");
        chk("t2_hold_seen", 64'(hold_total > 0), 64'd1);
        chk("t2_hold_stable", 64'(hold_bad), 64'd0);
        chk("t2_done_cnt", 64'(done_cnt), 64'd1);
        ready_mode = 0;
        repeat (2) cycle();

        // Step qualification
        halt = 1'b1;
        step_cnt = 0;
        cycle();
        chk("st_en_halt", 64'(debug_en), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            cycle();
            step_req = 1'b0;
            chk($sformatf("st_pulse%0d", i), 64'(debug_step), 64'd1);
            cycle();
            chk($sformatf("st_width%0d", i), 64'(debug_step), 64'd0);
            repeat (3) cycle();
        end
        chk("st_count", 64'(step_cnt), 64'd3);
        halt = 1'b0;
        step_cnt = 0;
        step_req = 1'b1;
        cycle();
        step_req = 1'b0;
        repeat (3) cycle();
        chk("st_nohalt", 64'(step_cnt), 64'd0);

`ifdef DEBUG_SCANNER_CHECKSUM_EN
        // Checksum frame for a known word
        mem[1] = 32'h1234_5678;
        start_scan(1'b0);
        wait_done("cs");
        cycle();
        chk("cs_b0", 64'(got[FB + 0]), 64'h01);
        chk("cs_b1", 64'(got[FB + 1]), 64'h12);
        chk("cs_b2", 64'(got[FB + 2]), 64'h34);
        chk("cs_b3", 64'(got[FB + 3]), 64'h56);
        chk("cs_b4", 64'(got[FB + 4]), 64'h78);
        chk("cs_b5", 64'(got[FB + 5]), 64'h09);
`endif

        // Random data, random backpressure
        for (int a = 0; a < 128; a++) mem[a] = $urandom;
        ready_mode = 2;
        start_scan(1'b0);
        wait_done("rnd");
        cycle();
        compare_bytes("rnd");
        chk("rnd_hold_stable", 64'(hold_bad), 64'd0);

        // Collisions: scan+step together in IDLE, then both again mid-sweep
        halt = 1'b1;
        for (int a = 0; a < 128; a++) mem[a] = $urandom;
        start_scan(1'b1);
        chk("col_step_lost", 64'(debug_step), 64'd0);
        chk("col_busy", 64'(busy), 64'd1);
        repeat (20) cycle();
        scan_req = 1'b1;
        step_req = 1'b1;
        cycle();
        scan_req = 1'b0;
        step_req = 1'b0;
        wait_done("col");
        cycle();
        compare_bytes("col");
        chk("col_steps", 64'(step_cnt), 64'd0);
        chk("col_done_cnt", 64'(done_cnt), 64'd1);
        repeat (15) cycle();
        chk("col_not_queued", 64'(busy), 64'd0);
        halt = 1'b0;
        ready_mode = 0;
        cycle();

        // Reset during byte 3 of address 2
        start_scan(1'b0);
        n = 0;
        while (got.size() < 2 * FB + 2 && n < 500) begin
            cycle();
            n++;
        end
        chk("ra_reached", 64'(got.size()), 64'(2 * FB + 2));
        chk("ra_pre_valid", 64'(out_valid), 64'd1);
        chk("ra_pre_addr", 64'(debug_addr), 64'(FIRST + 2));
        rst = 1'b1;
        #1;
        chk("ra_valid_drop", 64'(out_valid), 64'd0);
        chk("ra_busy_drop", 64'(busy), 64'd0);
        chk("ra_en_drop", 64'(debug_en), 64'd0);
        cycle();
        rst = 1'b0;
        repeat (5) cycle();
        chk("ra_no_done", 64'(done_cnt), 64'd0);
        chk("ra_idle", 64'(busy), 64'd0);
        for (int a = 0; a < 128; a++) mem[a] = $urandom;
        start_scan(1'b0);
        chk("ra_restart_addr", 64'(debug_addr), 64'(FIRST));
        wait_done("ra");
        cycle();
        compare_bytes("ra");
        chk("ra_done_cnt", 64'(done_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
